// File: rtl/fp_cmp_issue.sv
// fp_cmp_issue: initiator-side front end for the fp_cmp compute unit.
// Splits packed single-precision operand pairs into fields, issues them with a
// one-cycle src_valid strobe, and queues dst_valid results in a credit-protected
// FIFO that drains to a valid/ready output stream.
// Optional watchdog: define FP_CMP_ISSUE_WDOG_EN to build it; otherwise
// err_timeout is tied low.
module fp_cmp_issue #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2,
   parameter int CNT_W      = 3
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_a,
   input  logic [31:0]   in_b,
   output logic          enable,
   output logic          src_valid,
   output logic [22:0]   a_man,
   output logic [7:0]    a_exp,
   output logic          a_sign,
   output logic [22:0]   b_man,
   output logic [7:0]    b_exp,
   output logic          b_sign,
   input  logic [22:0]   r_man,
   input  logic [7:0]    r_exp,
   input  logic          r_sign,
   input  logic          dst_valid,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_r,
   output logic          err_unexp,
   output logic          err_timeout
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W:0]   DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

   logic [CNT_W-1:0]   outstanding;
   logic [CNT_W-1:0]   count;
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [31:0]        mem [FIFO_DEPTH];
   logic [CNT_W:0]     credit_used;
   logic               accept;
   logic               wr_ok;
   logic               pop;

   // Credit check: every accepted op must own a FIFO slot until it is popped
   always_comb begin
      credit_used = {1'b0, outstanding} + {1'b0, count};
      in_ready    = enable && (credit_used < DEPTH_L);
      accept      = in_valid && in_ready;
      wr_ok       = dst_valid && (outstanding != '0);
      out_valid   = (count != '0);
      pop         = out_valid && out_ready;
      out_r       = mem[rd_ptr];
   end

   // Enable, issue registers and operand field split
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         enable    <= 1'b0;
         src_valid <= 1'b0;
         a_sign    <= 1'b0;
         a_exp     <= '0;
         a_man     <= '0;
         b_sign    <= 1'b0;
         b_exp     <= '0;
         b_man     <= '0;
      end else begin
         enable    <= 1'b1;
         src_valid <= accept;
         if (accept) begin
            a_sign <= in_a[31];
            a_exp  <= in_a[30:23];
            a_man  <= in_a[22:0];
            b_sign <= in_b[31];
            b_exp  <= in_b[30:23];
            b_man  <= in_b[22:0];
         end
      end
   end

   // Outstanding/occupancy counters, pointers and the unexpected-result flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         err_unexp   <= 1'b0;
      end else begin
         case ({accept, wr_ok})
            2'b10:   outstanding <= outstanding + CNT_ONE;
            2'b01:   outstanding <= outstanding - CNT_ONE;
            default: outstanding <= outstanding;
         endcase
         case ({wr_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (wr_ok)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         if (dst_valid && (outstanding == '0))
            err_unexp <= 1'b1;
      end
   end

   // Result storage; contents are only meaningful where count says so
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= {r_sign, r_exp, r_man};
   end

`ifdef FP_CMP_ISSUE_WDOG_EN
   logic [7:0] wdog;

   // Watchdog: counts idle cycles while results are owed; flag fires as it hits 255
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdog        <= '0;
         err_timeout <= 1'b0;
      end else if (dst_valid || (outstanding == '0)) begin
         wdog <= '0;
      end else if (wdog != 8'hFF) begin
         wdog <= wdog + 8'd1;
         if (wdog == 8'hFE)
            err_timeout <= 1'b1;
      end
   end
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/fp_cmp_issue.md
Name: fp_cmp_issue

Overview:
Initiator-side front end for the fp_cmp compute unit. It accepts packed IEEE-754 single-precision operand pairs on a valid/ready stream and splits them into sign, exponent and mantissa fields. It issues each pair to fp_cmp with a registered src_valid pulse, and collects the dst_valid results into a result FIFO that drains to a valid/ready output stream. A credit counter ensures every in-flight result has a guaranteed FIFO slot, so the FIFO never overflows.

Parameters:
FIFO_DEPTH, 4, result FIFO entries; must be a power of two and at least 2; also the maximum number of operations in flight plus queued results
FIFO_AW, 2, log2(FIFO_DEPTH)
CNT_W, 3, width of the occupancy and outstanding counters; must be at least clog2(FIFO_DEPTH+1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted this cycle when in_valid is also high
in_a  in  32  operand A, packed {sign, exp[7:0], man[22:0]}
in_b  in  32  operand B, same packing
enable  out  1  pipeline enable to fp_cmp
src_valid  out  1  issue strobe to fp_cmp
a_man  out  23  operand A mantissa
a_exp  out  8  operand A exponent
a_sign  out  1  operand A sign
b_man  out  23  operand B mantissa
b_exp  out  8  operand B exponent
b_sign  out  1  operand B sign
r_man  in  23  result mantissa from fp_cmp
r_exp  in  8  result exponent from fp_cmp
r_sign  in  1  result sign from fp_cmp
dst_valid  in  1  result strobe from fp_cmp
out_valid  out  1  FIFO head is valid
out_ready  in  1  downstream accepts the FIFO head
out_r  out  32  result, packed {r_sign, r_exp, r_man}
err_unexp  out  1  sticky: dst_valid arrived with no operation outstanding
err_timeout  out  1  sticky watchdog flag; see Optional Feature

Behaviour:
- Reset (rstn=0, asynchronous): enable=0, src_valid=0, all operand outputs=0, outstanding=0, FIFO count=0, read and write pointers=0, out_valid=0, err_unexp=0, err_timeout=0.
- enable is a register. It goes to 1 on the first clock edge after rstn deasserts and stays 1 until the next reset.
- in_ready = enable && (outstanding + count < FIFO_DEPTH). It is combinational and does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, the next edge:
  - registers the split fields of in_a and in_b onto a_*/b_*;
  - sets src_valid=1 for exactly one cycle per accept;
  - increments outstanding.
- On cycles with no accept: src_valid=0 and the operand outputs hold their previous values.
- Back-to-back accepts are supported, giving one issue per cycle.
- Issue latency is 1 cycle from accept to src_valid.
- Result capture: when dst_valid=1, write {r_sign, r_exp, r_man} at the write pointer, advance the write pointer (modulo FIFO_DEPTH), and decrement outstanding.
- If dst_valid=1 while outstanding=0: set err_unexp, drop the result, and leave the counters unchanged.
- Accept and dst_valid in the same cycle: outstanding is unchanged.
- FIFO count tracks the number of stored results:
  - increments on a write;
  - decrements on a pop (out_valid && out_ready);
  - is unchanged when a write and a pop occur together.
- out_valid = (count != 0) and out_r = mem[read pointer]. Both are combinational from registered state. A pop advances the read pointer modulo FIFO_DEPTH.
- Result latency: a dst_valid at edge N makes out_valid=1 after edge N.
- FIFO full: credits guarantee count + outstanding <= FIFO_DEPTH, so a write can never find the FIFO full.
- Pointers wrap modulo FIFO_DEPTH with no bubble.
- Result order is the same as issue order.
- out_r remains stable while out_valid=1 and out_ready=0.
- Error flags clear only on reset.
- Reset mid-operation discards all in-flight and queued results. dst_valid pulses that arrive after reset then set err_unexp.

Optional Feature:
FP_CMP_ISSUE_WDOG_EN
- Defined: an 8-bit watchdog counter.
  - Resets to 0 on any dst_valid, or whenever outstanding=0.
  - Otherwise increments each cycle, saturating at 255.
  - Reaching 255 sets the sticky err_timeout flag.
- Not defined: no counter is built and err_timeout is tied to 0.

Test Plan:
- Single op: in_a=0x3F800000, in_b=0xC0200000, accept at edge 1 -> at edge 2, src_valid=1, a_sign=0, a_exp=0x7F, a_man=0, b_sign=1, b_exp=0x80, b_man=0x200000. Then dst_valid with r=0x3F800000 -> out_valid=1, out_r=0x3F800000.
- Credit stall: hold out_ready=0 and issue 4 ops, returning 4 results -> in_ready=0 after the 4th accept; a 5th in_valid is not accepted. One pop -> in_ready=1.
- Ordering and wrap: stream 10 ops with results 0x00000001..0x0000000A while out_ready toggles 1,0 -> out_r sequence is exactly 1..10, with no loss or duplicate across the pointer wrap.
- Simultaneous events: accept and dst_valid in the same cycle with outstanding=1 -> outstanding stays 1. Write and pop in the same cycle with count=2 -> count stays 2.
- Unexpected result: dst_valid=1 right after reset -> err_unexp=1, out_valid stays 0. Assert rstn=0 -> err_unexp=0.
- Watchdog (FP_CMP_ISSUE_WDOG_EN defined): issue 1 op and never return dst_valid -> err_timeout=1 exactly 255 cycles after src_valid. Without the macro, err_timeout stays 0.
